// File: rtl/ysyx_22041207_muldiv_iter.sv
// ysyx_22041207_muldiv_iter: iterative RV64M multiply/divide unit with valid/ready handshakes.
// Optional zero-operand early exit: define YSYX_22041207_MULDIV_FASTPATH_EN.
module ysyx_22041207_muldiv_iter #(
  parameter int XLEN   = 64,
  parameter int UNROLL = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_op,
  input  logic            in_word,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_res,
  output logic            busy
);
  localparam int H  = XLEN / 2;
  localparam int CW = $clog2(XLEN) + 1;
  typedef enum logic [2:0] {IDLE, PREP, BUSY, FIX, DONE} state_t;
  state_t              state_q;
  logic [2:0]          op_q;
  logic                word_q, neg_q, in_ready_q, out_valid_q, busy_q;
  logic [XLEN-1:0]     a_q, b_q, d_q, m_q, res_q;
  logic [2*XLEN-1:0]   acc_q;
  logic [CW-1:0]       cnt_q;
  logic                is_mul, sa, sb, an, bn, neg_d, ge;
  logic [XLEN-1:0]     amag, bmag, m_init, m_s, qr, v, res_d;
  logic [2*XLEN-1:0]   acc_init, acc_s, prod;
  logic [XLEN:0]       t;
`ifdef YSYX_22041207_MULDIV_FASTPATH_EN
  logic                fast;
`endif
  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] x, input logic w, input logic n);
    logic [XLEN-1:0] r;
    r = w ? {{H{1'b0}}, x[H-1:0]} : x;
    r = n ? -r : r;
    return w ? {{H{1'b0}}, r[H-1:0]} : r;
  endfunction
  // Operands are reduced to magnitudes; the result sign is reapplied in FIX.
  always_comb begin
    is_mul   = !op_q[2];
    sa       = is_mul ? (!word_q && (op_q == 3'd1 || op_q == 3'd2)) : !op_q[0];
    sb       = is_mul ? (!word_q && op_q == 3'd1) : !op_q[0];
    an       = sa && (word_q ? a_q[H-1] : a_q[XLEN-1]);
    bn       = sb && (word_q ? b_q[H-1] : b_q[XLEN-1]);
    amag     = mag(a_q, word_q, an);
    bmag     = mag(b_q, word_q, bn);
    m_init   = word_q ? {amag[H-1:0], {H{1'b0}}} : amag;
    neg_d    = is_mul ? an ^ bn : op_q[1] ? an : (an ^ bn) && (bmag != '0);
    acc_init = is_mul ? '0 : {{XLEN{1'b0}}, m_init};
`ifdef YSYX_22041207_MULDIV_FASTPATH_EN
    fast     = is_mul ? (amag == '0 || bmag == '0) : bmag == '0;
    acc_init = fast ? (is_mul ? '0 : {amag, {XLEN{1'b1}}}) : acc_init;
`endif
  end
  // MSB-first shift-add multiply and restoring divide, UNROLL steps per cycle.
  always_comb begin
    acc_s = acc_q;
    m_s   = m_q;
    t     = '0;
    ge    = 1'b0;
    for (int i = 0; i < UNROLL; i++) begin
      if (is_mul) begin
        acc_s = (acc_s << 1) + (m_s[XLEN-1] ? {{XLEN{1'b0}}, d_q} : '0);
        m_s   = m_s << 1;
      end else begin
        t     = acc_s[2*XLEN-1:XLEN-1];
        ge    = t >= {1'b0, d_q};
        acc_s = {ge ? t[XLEN-1:0] - d_q : t[XLEN-1:0], acc_s[XLEN-2:0], ge};
      end
    end
  end
  always_comb begin
    prod  = neg_q ? -acc_q : acc_q;
    qr    = op_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
    v     = is_mul ? ((word_q || op_q == 3'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN])
                   : (neg_q ? -qr : qr);
    res_d = word_q ? {{H{v[H-1]}}, v[H-1:0]} : v;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= '0;
      word_q      <= 1'b0;
      neg_q       <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      d_q         <= '0;
      m_q         <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      res_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else if (flush) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          op_q       <= in_op;
          word_q     <= in_word;
          a_q        <= in_a;
          b_q        <= in_b;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b1;
          state_q    <= PREP;
        end
        PREP: begin
          acc_q   <= acc_init;
          m_q     <= m_init;
          d_q     <= bmag;
          neg_q   <= neg_d;
          cnt_q   <= word_q ? CW'(H / UNROLL - 1) : CW'(XLEN / UNROLL - 1);
`ifdef YSYX_22041207_MULDIV_FASTPATH_EN
          state_q <= fast ? FIX : BUSY;
`else
          state_q <= BUSY;
`endif
        end
        BUSY: begin
          acc_q   <= acc_s;
          m_q     <= m_s;
          cnt_q   <= cnt_q - 1'b1;
          state_q <= cnt_q == '0 ? FIX : BUSY;
        end
        FIX: begin
          res_q       <= res_d;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_res   = res_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_ysyx_22041207_muldiv_iter.sv
// tb_ysyx_22041207_muldiv_iter: directed and random checks of the muldiv unit against an arithmetic model.
module tb_ysyx_22041207_muldiv_iter;
  logic        clk = 1'b0, rst, flush, in_valid, in_ready, in_word, out_valid, out_ready, busy;
  logic [2:0]  in_op;
  logic [63:0] in_a, in_b, out_res, res;
  int          checks = 0, failures = 0, lat, stale;

  always #5 clk = ~clk;

  ysyx_22041207_muldiv_iter dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_word(in_word), .in_a(in_a), .in_b(in_b), .out_valid(out_valid),
    .out_ready(out_ready), .out_res(out_res), .busy(busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] sx32(input logic [31:0] x);
    return {{32{x[31]}}, x};
  endfunction

  function automatic logic [63:0] model(input logic [2:0] op, input logic w, input logic [63:0] a, input logic [63:0] b);
    logic [31:0]         a32, b32, r32;
    logic signed [31:0]  s32a, s32b, s32r;
    logic signed [63:0]  s64a, s64b, s64r;
    logic [127:0]        ea, eb, p;
    a32 = a[31:0];
    b32 = b[31:0];
    s32a = a32;
    s32b = b32;
    s64a = a;
    s64b = b;
    if (w) begin
      if (op == 3'd4 || op == 3'd6) begin
        if (b32 == 32'd0) r32 = op == 3'd4 ? 32'hFFFF_FFFF : a32;
        else if (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) r32 = op == 3'd4 ? a32 : 32'd0;
        else begin
          s32r = op == 3'd4 ? s32a / s32b : s32a % s32b;
          r32 = s32r;
        end
      end else if (op == 3'd5) r32 = b32 == 0 ? 32'hFFFF_FFFF : a32 / b32;
      else if (op == 3'd7) r32 = b32 == 0 ? a32 : a32 % b32;
      else r32 = a32 * b32;
      return sx32(r32);
    end
    if (op == 3'd4 || op == 3'd6) begin
      if (b == 64'd0) return op == 3'd4 ? 64'hFFFF_FFFF_FFFF_FFFF : a;
      if (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) return op == 3'd4 ? a : 64'd0;
      s64r = op == 3'd4 ? s64a / s64b : s64a % s64b;
      return s64r;
    end
    if (op == 3'd5) return b == 0 ? 64'hFFFF_FFFF_FFFF_FFFF : a / b;
    if (op == 3'd7) return b == 0 ? a : a % b;
    ea = (op == 3'd1 || op == 3'd2) ? {{64{a[63]}}, a} : {64'd0, a};
    eb = (op == 3'd1) ? {{64{b[63]}}, b} : {64'd0, b};
    p  = ea * eb;
    return op == 3'd0 ? p[63:0] : p[127:64];
  endfunction

  function automatic int exp_lat(input logic [2:0] op, input logic w, input logic [63:0] a, input logic [63:0] b);
    logic [63:0] aw, bw;
    aw = w ? {32'd0, a[31:0]} : a;
    bw = w ? {32'd0, b[31:0]} : b;
`ifdef YSYX_22041207_MULDIV_FASTPATH_EN
    if (op[2] ? bw == 0 : (aw == 0 || bw == 0)) return 2;
`else
    if (aw == bw && aw == 64'd1 && op == 3'd7) return (w ? 32 : 64) + 2;
`endif
    return (w ? 32 : 64) + 2;
  endfunction

  task automatic run(input logic [2:0] op, input logic w, input logic [63:0] a, input logic [63:0] b,
                     input int hold, input string tag, output logic [63:0] r, output int l);
    @(negedge clk);
    check({tag, " in_ready"}, {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1; in_op = op; in_word = w; in_a = a; in_b = b;
    @(negedge clk);
    in_valid = 1'b0; in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom}; in_op = 3'($urandom);
    check({tag, " busy"}, {63'd0, busy}, 64'd1);
    l = 0;
    while (out_valid !== 1'b1 && l < 300) begin
      @(negedge clk);
      l++;
    end
    r = out_res;
    check({tag, " res"}, r, model(op, w, a, b));
    check({tag, " lat"}, 64'(l), 64'(exp_lat(op, w, a, b)));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, " hold valid"}, {63'd0, out_valid}, 64'd1);
      check({tag, " hold res"}, out_res, r);
      check({tag, " hold in_ready"}, {63'd0, in_ready}, 64'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, " post valid"}, {63'd0, out_valid}, 64'd0);
    check({tag, " post in_ready"}, {63'd0, in_ready}, 64'd1);
  endtask

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 7))
      0: return 64'd0;
      1: return 64'hFFFF_FFFF_FFFF_FFFF;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'd1;
      4: return {32'd0, 32'($urandom_range(0, 300))};
      5: return {$urandom, 32'h8000_0000};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = '0; in_word = 1'b0;
    in_a = '0; in_b = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset in_ready", {63'd0, in_ready}, 64'd1);
    check("reset out_valid", {63'd0, out_valid}, 64'd0);
    check("reset out_res", out_res, 64'd0);
    check("reset busy", {63'd0, busy}, 64'd0);

    run(3'd0, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 0, "mul", res, lat);
    check("mul const", res, 64'hFFFF_FFFF_FFFF_FFFA);
    run(3'd3, 1'b0, '1, '1, 0, "mulhu", res, lat);
    check("mulhu const", res, 64'hFFFF_FFFF_FFFF_FFFE);
    run(3'd1, 1'b0, '1, '1, 0, "mulh", res, lat);
    check("mulh const", res, 64'd0);
    run(3'd2, 1'b0, '1, 64'd2, 0, "mulhsu", res, lat);
    check("mulhsu const", res, 64'hFFFF_FFFF_FFFF_FFFF);
    run(3'd4, 1'b0, 64'h8000_0000_0000_0000, '1, 0, "div ovf", res, lat);
    check("div ovf const", res, 64'h8000_0000_0000_0000);
    run(3'd6, 1'b0, 64'h8000_0000_0000_0000, '1, 0, "rem ovf", res, lat);
    check("rem ovf const", res, 64'd0);
    run(3'd5, 1'b0, 64'd7, 64'd0, 0, "divu0", res, lat);
    check("divu0 const", res, 64'hFFFF_FFFF_FFFF_FFFF);
    run(3'd7, 1'b0, 64'd7, 64'd0, 0, "remu0", res, lat);
    check("remu0 const", res, 64'd7);
    run(3'd4, 1'b1, 64'hDEAD_0000_FFFF_FFF9, 64'd2, 0, "divw", res, lat);
    check("divw const", res, 64'hFFFF_FFFF_FFFF_FFFD);
    check("divw lat const", 64'(lat), 64'd34);
    run(3'd6, 1'b1, 64'hDEAD_0000_FFFF_FFF9, 64'd2, 0, "remw", res, lat);
    check("remw const", res, 64'hFFFF_FFFF_FFFF_FFFF);
    run(3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd0, 0, "div0 neg", res, lat);
    check("div0 neg const", res, 64'hFFFF_FFFF_FFFF_FFFF);

    @(negedge clk);
    in_valid = 1'b1; in_op = 3'd0; in_word = 1'b0; in_a = 64'd9; in_b = 64'd9;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush in_ready", {63'd0, in_ready}, 64'd1);
    check("flush busy", {63'd0, busy}, 64'd0);
    stale = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("flush stale", 64'(stale), 64'd0);
    run(3'd0, 1'b0, 64'd5, 64'd6, 0, "mul after flush", res, lat);
    check("mul after flush const", res, 64'd30);

    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; in_op = 3'd0; in_a = 64'd1; in_b = 64'd1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush+valid busy", {63'd0, busy}, 64'd0);
    check("flush+valid in_ready", {63'd0, in_ready}, 64'd1);

    run(3'd5, 1'b0, 64'd100, 64'd7, 5, "stall", res, lat);
    check("stall const", res, 64'd14);

    for (int n = 0; n < 150; n++) begin
      logic [2:0]  op;
      logic        w;
      logic [63:0] a, b;
      op = 3'($urandom_range(0, 7));
      w  = 1'($urandom_range(0, 1));
      a  = pick();
      b  = pick();
      run(op, w, a, b, (n % 25 == 0) ? 2 : 0, $sformatf("rnd%0d op%0d w%0d", n, op, w), res, lat);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
